// File: rtl/rv32_dmem_ctrl.sv
// RV32I data-memory controller: one access at a time through a
// read-modify-write word buffer, with alignment/range fault detection.
module rv32_dmem_ctrl #(
  parameter int DEPTH = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int          AW      = $clog2(DEPTH);
  localparam logic [31:0] DEPTH_U = 32'(DEPTH);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_e;

  state_e        state_q;
  logic [AW+1:0] addr_q;
  logic          we_q;
  logic [2:0]    f3_q;
  logic [31:0]   wdata_q, buf_q;
  logic          rsp_valid_q, rsp_err_q;
  logic [31:0]   rsp_rdata_q;
  logic [31:0]   mem [DEPTH];

  logic          fault_d;
  logic [31:0]   mem_rd, ld_sh, ld_d, wd_rep, merged_d;
  logic [3:0]    be;

  // Fault check on the raw request, evaluated in IDLE at the accept edge.
  always_comb begin
    fault_d = 1'b0;
    case (req_funct3)
      3'd0:    fault_d = 1'b0;
      3'd1:    fault_d = req_addr[0];
      3'd2:    fault_d = |req_addr[1:0];
      3'd4:    fault_d = req_we;
      3'd5:    fault_d = req_we | req_addr[0];
      default: fault_d = 1'b1;
    endcase
    if ({2'b00, req_addr[31:2]} >= DEPTH_U) fault_d = 1'b1;
  end

  assign mem_rd = mem[addr_q[AW+1:2]];
  assign ld_sh  = mem_rd >> {addr_q[1:0], 3'b000};

  always_comb begin
    case (f3_q)
      3'd0:    ld_d = {{24{ld_sh[7]}}, ld_sh[7:0]};
      3'd1:    ld_d = {{16{ld_sh[15]}}, ld_sh[15:0]};
      3'd4:    ld_d = {24'b0, ld_sh[7:0]};
      3'd5:    ld_d = {16'b0, ld_sh[15:0]};
      default: ld_d = ld_sh;
    endcase
  end

  // Store data is replicated across lanes so the byte enables alone pick the target.
  always_comb begin
    be     = 4'hf;
    wd_rep = wdata_q;
    case (f3_q[1:0])
      2'd0: begin
        be     = 4'b0001 << addr_q[1:0];
        wd_rep = {4{wdata_q[7:0]}};
      end
      2'd1: begin
        be     = 4'b0011 << {addr_q[1], 1'b0};
        wd_rep = {2{wdata_q[15:0]}};
      end
      default: ;
    endcase
    for (int i = 0; i < 4; i++)
      merged_d[8*i +: 8] = be[i] ? wd_rep[8*i +: 8] : buf_q[8*i +: 8];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      we_q        <= 1'b0;
      f3_q        <= 3'd0;
      wdata_q     <= '0;
      buf_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      case (state_q)
        IDLE: if (req_valid) begin
          addr_q  <= req_addr[AW+1:0];
          we_q    <= req_we;
          f3_q    <= req_funct3;
          wdata_q <= req_wdata;
          if (fault_d) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
          end else begin
            state_q <= READ;
          end
        end
        READ: begin
          buf_q <= mem_rd;
          if (we_q) begin
            state_q <= WRITE;
          end else begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= ld_d;
          end
        end
        WRITE: begin
          buf_q       <= merged_d;
          state_q     <= RESP;
          rsp_valid_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Memory has no reset; an async reset in WRITE leaves state IDLE before the edge.
  always_ff @(posedge clk) begin
    if (state_q == WRITE) mem[addr_q[AW+1:2]] <= merged_d;
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
endmodule
